// File: rtl/groestl_invmix_serial.sv
// Byte-serial GF(2^8) circulant multiplier that undoes Groestl MixBytes on one 64-bit column.
// Optional build macro GRS_INVMIX_OUTREG_EN adds an output register stage (latency 9 instead of 8).
module groestl_invmix_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        coef_wr,
  input  logic [2:0]  coef_idx,
  input  logic [7:0]  coef_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    XFER,
    DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  coef [8];
  logic [63:0] col;
  logic [63:0] asm_q;
  logic [2:0]  cnt;
  logic [7:0]  ybyte;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // col always holds x_i..x_(i+7) MSB-first, so coefficient k pairs with byte slot k.
  always_comb begin
    ybyte = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      ybyte ^= gf_mul(coef[k], col[8*(7-k) +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = BUSY;
`ifdef GRS_INVMIX_OUTREG_EN
      BUSY: if (cnt == 3'd7) state_nx = XFER;
`else
      BUSY: if (cnt == 3'd7) state_nx = DONE;
`endif
      XFER: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      coef  <= '{0: 8'h01, default: 8'h00};
      col   <= '0;
      asm_q <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && coef_wr) coef[coef_idx] <= coef_data;
      if (state == IDLE && in_valid) begin
        col <= in_data;
        cnt <= '0;
      end else if (state == BUSY) begin
        // {~cnt,3'b000} == 8*(7-cnt): byte i lands in slot i counted from the MSB.
        asm_q[{~cnt, 3'b000} +: 8] <= ybyte;
        col <= {col[55:0], col[63:56]};
        cnt <= cnt + 3'd1;
      end
    end
  end

`ifdef GRS_INVMIX_OUTREG_EN
  logic [63:0] out_q;
  always_ff @(posedge clk) begin
    if (rst)                out_q <= '0;
    else if (state == XFER) out_q <= asm_q;
  end
  always_comb out_data = out_q;
`else
  always_comb out_data = asm_q;
`endif

endmodule

// File: tb/tb_groestl_invmix_serial.sv
// Directed bench for groestl_invmix_serial: handshakes, latency, coefficient gating, reset, inverse MixBytes.
module tb_groestl_invmix_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_wr = 1'b0;
  logic [2:0]  coef_idx = '0;
  logic [7:0]  coef_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int nvec = 0;
  int nfail = 0;

`ifdef GRS_INVMIX_OUTREG_EN
  localparam int LAT = 9;
  localparam int PER = 11;
`else
  localparam int LAT = 8;
  localparam int PER = 10;
`endif
  localparam logic [63:0] FWD_ROW = 64'h0202030405030507;

  always #5 clk = ~clk;

  groestl_invmix_serial dut (
    .clk(clk), .rst(rst), .coef_wr(coef_wr), .coef_idx(coef_idx), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Horner-style reference multiply, mod 0x11B
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      if (a[i]) p ^= b;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int v = 1; v < 256; v++) if (gmul(a, 8'(v)) == 8'h01) return 8'(v);
    return 8'h00;
  endfunction

  function automatic logic [63:0] mixfwd(input logic [63:0] x);
    logic [63:0] r;
    logic [63:0] y;
    logic [7:0]  acc;
    r = FWD_ROW;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      acc = '0;
      for (int k = 0; k < 8; k++) acc ^= gmul(r[8*(7-k) +: 8], x[8*(7-((i+k)%8)) +: 8]);
      y[8*(7-i) +: 8] = acc;
    end
    return y;
  endfunction

  // Solve sum_m b[(j-m) mod 8] * c[m] = delta(j) for the inverse circulant row
  function automatic logic [63:0] inv_row();
    logic [63:0] r;
    logic [63:0] res;
    logic [7:0]  m [8][9];
    logic [7:0]  t;
    logic [7:0]  f;
    int          p;
    r = FWD_ROW;
    res = '0;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 8; c++) m[j][c] = r[8*(7-((j-c+8)%8)) +: 8];
      m[j][8] = (j == 0) ? 8'h01 : 8'h00;
    end
    for (int c = 0; c < 8; c++) begin
      p = c;
      while (p < 7 && m[p][c] == 8'h00) p++;
      for (int q = 0; q < 9; q++) begin t = m[c][q]; m[c][q] = m[p][q]; m[p][q] = t; end
      f = ginv(m[c][c]);
      for (int q = 0; q < 9; q++) m[c][q] = gmul(f, m[c][q]);
      for (int j = 0; j < 8; j++) begin
        if (j != c) begin
          f = m[j][c];
          for (int q = 0; q < 9; q++) m[j][q] ^= gmul(f, m[c][q]);
        end
      end
    end
    for (int j = 0; j < 8; j++) res[8*(7-j) +: 8] = m[j][8];
    return res;
  endfunction

  task automatic write_coef(input int k, input logic [7:0] v);
    coef_wr = 1'b1; coef_idx = 3'(k); coef_data = v;
    @(posedge clk); #1;
    coef_wr = 1'b0;
  endtask

  task automatic load_row(input logic [63:0] row);
    for (int k = 0; k < 8; k++) write_coef(k, row[8*(7-k) +: 8]);
  endtask

  task automatic start_column(input logic [63:0] x);
    int n;
    n = 0;
    in_data = x; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout: in_ready got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    nvec++; if (out_data !== 64'h0) begin nfail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL reset_in_ready_held: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL reset_in_ready_release: got %b expected 1", in_ready); end
  endtask

  task automatic test_identity();
    int lat;
    start_column(64'h0011223344556677);
    wait_out(lat);
    nvec++; if (lat != LAT) begin nfail++; $display("FAIL identity_latency: got %0d expected %0d", lat, LAT); end
    nvec++; if (out_data !== 64'h0011223344556677) begin nfail++; $display("FAIL identity_data: got %h expected 0011223344556677", out_data); end
    take_out();
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL identity_out_valid_drop: got %b expected 0", out_valid); end
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL identity_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_rotate();
    int lat;
    load_row(64'h0001000000000000);
    start_column(64'h0102030405060708);
    wait_out(lat);
    nvec++; if (out_data !== 64'h0203040506070801) begin nfail++; $display("FAIL rotate_data: got %h expected 0203040506070801", out_data); end
    take_out();
  endtask

  task automatic test_double();
    int lat;
    load_row(64'h0200000000000000);
    start_column(64'h8001000000000080);
    wait_out(lat);
    nvec++; if (out_data !== 64'h1B0200000000001B) begin nfail++; $display("FAIL double_data: got %h expected 1B0200000000001B", out_data); end
    take_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] d0;
    load_row(64'h0100000000000000);
    start_column(64'hDEADBEEF01234567);
    write_coef(0, 8'h05);
    wait_out(lat);
    d0 = out_data;
    nvec++; if (d0 !== 64'hDEADBEEF01234567) begin nfail++; $display("FAIL bp_data: got %h expected deadbeef01234567", d0); end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      nvec++; if (out_valid !== 1'b1) begin nfail++; $display("FAIL bp_hold_valid: cycle %0d got %b expected 1", c, out_valid); end
      nvec++; if (out_data !== d0) begin nfail++; $display("FAIL bp_hold_data: cycle %0d got %h expected %h", c, out_data, d0); end
      nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL bp_hold_in_ready: cycle %0d got %b expected 0", c, in_ready); end
    end
    take_out();
    start_column(64'h0123456789ABCDEF);
    wait_out(lat);
    nvec++; if (out_data !== 64'h0123456789ABCDEF) begin nfail++; $display("FAIL busy_coef_dropped: got %h expected 0123456789abcdef", out_data); end
    take_out();
  endtask

  task automatic test_inverse();
    int lat;
    logic [63:0] x;
    load_row(inv_row());
    for (int n = 0; n < 1000; n++) begin
      x = {$urandom(), $urandom()};
      start_column(mixfwd(x));
      wait_out(lat);
      nvec++; if (out_data !== x) begin nfail++; $display("FAIL inverse_col%0d: got %h expected %h", n, out_data, x); end
      take_out();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int cnt;
    int t [2];
    n = 0; cnt = 0; t = '{0, 0};
    in_data = 64'h0F0E0D0C0B0A0908; in_valid = 1'b1; out_ready = 1'b1;
    while (cnt < 2 && n < 60) begin
      if (in_ready === 1'b1) begin t[cnt] = n; cnt++; end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    nvec++;
    if (cnt != 2 || t[1] - t[0] != PER) begin
      nfail++; $display("FAIL b2b_period: got %0d (accepts %0d) expected %0d", t[1] - t[0], cnt, PER);
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    int lat;
    load_row(64'h0200000000000000);
    start_column(64'h1122334455667788);
    repeat (3) begin @(posedge clk); #1; end
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL midop_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    nvec++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL midop_out_valid: got %b expected 0", out_valid); end
    nvec++; if (out_data !== 64'h0) begin nfail++; $display("FAIL midop_out_data: got %h expected 0", out_data); end
    nvec++; if (busy !== 1'b0) begin nfail++; $display("FAIL midop_busy: got %b expected 0", busy); end
    nvec++; if (in_ready !== 1'b0) begin nfail++; $display("FAIL midop_in_ready_rst: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nfail++; $display("FAIL midop_in_ready_release: got %b expected 1", in_ready); end
    start_column(64'hA55A3CC30FF09669);
    wait_out(lat);
    nvec++; if (out_data !== 64'hA55A3CC30FF09669) begin nfail++; $display("FAIL midop_identity_data: got %h expected a55a3cc30ff09669", out_data); end
    take_out();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate();
    test_double();
    test_backpressure();
    test_inverse();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
